tile_map_writer: RTL and testbench
==================================

// Module: tile_map_writer
// PURPOSE
//  Owns the playfield tile map as registers and is the write side of the flattened
//  map bus read by the tile-select muxes (30x40 tiles, 8 bits each, 12-bit linear index).
//  On reset/clear it walks the map, loading the default maze: wall border, dots inside.
//  Then it accepts single-tile writes over a valid/ready handshake (dot eaten, power-up).
//  It keeps a live count of dot tiles for level-complete detection.
// PARAMETERS
//  ROWS       30     tile rows
//  COLS       40     tile columns
//  TILE_W     8      bits per tile code
//  DOT_CODE   8'h01  tile code counted as a dot
//  WALL_CODE  8'h02  tile code loaded on the border during init
// PORTS
//  Clk        in   1                    system clock, all logic on rising edge
//  Reset      in   1                    synchronous, active-high reset
//  clear      in   1                    restart init sequence (sampled only in IDLE)
//  wr_valid   in   1                    write request valid
//  wr_ready   out  1                    write request can be accepted this cycle
//  wr_index   in   12                   linear tile index = row*COLS + col
//  wr_data    in   TILE_W               new tile code
//  wr_err     out  1                    1-cycle pulse: accepted request had index >= ROWS*COLS
//  map_out    out  ROWS*COLS*TILE_W     tile k at [TILE_W*k +: TILE_W]
//  init_done  out  1                    map holds valid contents
//  dot_count  out  11                   number of tiles currently equal to DOT_CODE
// BEHAVIOUR
//  Reset (synchronous, active-high, overrides all):
//   state=INIT, idx=0, map_out=0, dot_count=0, init_done=0, wr_err=0.
//  FSM states: INIT, IDLE. Outputs are registered except wr_ready.
//  INIT:
//   - Each cycle writes tile idx, then idx++.
//   - Code = WALL_CODE if row==0, row==ROWS-1, col==0 or col==COLS-1; else DOT_CODE.
//   - Row/col are tracked by counters, not by dividing idx.
//   - dot_count increments on each DOT_CODE write.
//   - After writing idx=ROWS*COLS-1: next state IDLE, init_done=1 on the same edge.
//   - Timing: init_done rises on the 1200th rising edge after Reset deasserts.
//   - Final dot_count = (ROWS-2)*(COLS-2) = 1064.
//   - wr_ready=0 throughout; wr_valid is ignored.
//  IDLE:
//   - wr_ready = (state==IDLE) && !clear.
//   - Handshake: request accepted on an edge where wr_valid && wr_ready.
//   - wr_index/wr_data are sampled on that edge; write latency is 1 cycle.
//   - Master holds wr_valid and its fields until accepted. Back-to-back writes every cycle.
//   - In-range write: tile updated; dot_count updated on the same edge.
//     - old==DOT && new!=DOT: -1. old!=DOT && new==DOT: +1. Otherwise unchanged.
//   - Out-of-range write (index >= 1200): map and dot_count unchanged; wr_err=1 next cycle.
//   - wr_err returns to 0 the cycle after; it is 0 in all other cycles.
//   - Rewriting a tile with its current code: no visible change.
//  clear:
//   - clear=1 in IDLE: next edge -> INIT, idx=0, dot_count=0, init_done=0.
//   - map_out is retained and overwritten tile by tile.
//   - clear and wr_valid together: clear wins; wr_ready=0, so no write occurs.
//   - clear is ignored during INIT.
//  dot_count never underflows or overflows (max 1200 fits in 11 bits).
//   - Assertion: dot_count equals the population count of DOT_CODE tiles in every IDLE cycle.
// TESTING
//  1 Reset 2 cycles, release -> init_done=0 for 1199 edges, =1 at edge 1200.
//    Then: dot_count=1064, tile0=8'h02, tile41=8'h01, tile1199=8'h02.
//  2 IDLE, write idx41 data 8'h00 -> next cycle tile41=00, dot_count=1063, wr_err=0.
//    Rewrite 8'h01 -> 1064.
//  3 Write idx1200 data 8'h05 -> wr_err=1 for exactly 1 cycle; map and dot_count unchanged.
//  4 wr_valid held high 3 cycles, idx 41/42/43, data 00 -> all accepted back-to-back.
//    Result: dot_count=1061.
//  5 Assert clear with wr_valid high (idx 41, data 00) -> no write.
//    init_done=0 next cycle, then 1200 cycles later dot_count=1064 and tile41=01.
//  6 Reset at idx~600 mid-INIT -> map_out=0 next cycle; a full 1200-cycle init follows.

Source files
------------

// File: rtl/tile_map_writer_if.sv
// Single-tile write channel into the tile map.
//   wr_valid  master -> slave  request valid, held with its fields until accepted
//   wr_ready  slave  -> master request accepted on an edge where valid && ready
//   wr_index  master -> slave  linear tile index, row*COLS + col
//   wr_data   master -> slave  new tile code
//   wr_err    slave  -> master 1-cycle pulse after an accepted out-of-range index
interface tile_map_writer_if #(
   parameter int IDX_W  = 12,
   parameter int TILE_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [IDX_W-1:0]  wr_index;
   logic [TILE_W-1:0] wr_data;
   logic              wr_err;

   modport master (
      output wr_valid, wr_index, wr_data,
      input  wr_ready, wr_err
   );

   modport slave (
      input  wr_valid, wr_index, wr_data,
      output wr_ready, wr_err
   );
endinterface

// File: rtl/tile_map_writer.sv
// Playfield tile map held in registers, exposed as one flattened bus for the
// tile-select muxes. After reset or clear it loads the default maze (wall
// border, dots inside), then accepts single-tile writes and keeps a live count
// of dot tiles for level-complete detection.
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous active-high reset
//   clear      restart the maze load (honoured only in IDLE)
//   bus        write channel (valid/ready, index, data, error pulse)
//   map_out    tile k at [TILE_W*k +: TILE_W]
//   init_done  map holds valid contents
//   dot_count  number of tiles equal to DOT_CODE
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | writing the default maze, one tile per cycle, writes blocked
// IDLE  | map valid, accepting tile writes
module tile_map_writer #(
   parameter int                ROWS      = 30,
   parameter int                COLS      = 40,
   parameter int                TILE_W    = 8,
   parameter logic [TILE_W-1:0] DOT_CODE  = 8'h01,
   parameter logic [TILE_W-1:0] WALL_CODE = 8'h02
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        clear,
   tile_map_writer_if.slave            bus,
   output logic [ROWS*COLS*TILE_W-1:0] map_out,
   output logic                        init_done,
   output logic [10:0]                 dot_count
);

   localparam int NTILES = ROWS * COLS;
   localparam int IDX_W  = $clog2(NTILES);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int COL_W  = $clog2(COLS);

   typedef enum logic {INIT, IDLE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;

   logic              on_border;
   logic              wr_accept;
   logic              wr_in_range;
   logic [TILE_W-1:0] old_tile;

   assign bus.wr_ready = (state == IDLE) && !clear;
   assign wr_accept    = bus.wr_valid && bus.wr_ready;
   assign wr_in_range  = int'(bus.wr_index) < NTILES;

   always_comb begin
      on_border = (row == '0) || (row == ROW_W'(ROWS - 1)) ||
                  (col == '0) || (col == COL_W'(COLS - 1));
   end

   // Out-of-range indices would read past the map; such writes are dropped anyway.
   always_comb begin
      old_tile = '0;
      if (wr_in_range)
         old_tile = map_out[TILE_W*int'(bus.wr_index) +: TILE_W];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= INIT;
         idx        <= '0;
         row        <= '0;
         col        <= '0;
         map_out    <= '0;
         dot_count  <= '0;
         init_done  <= 1'b0;
         bus.wr_err <= 1'b0;
      end else begin
         bus.wr_err <= 1'b0;
         case (state)
            INIT: begin
               if (on_border) begin
                  map_out[TILE_W*int'(idx) +: TILE_W] <= WALL_CODE;
               end else begin
                  map_out[TILE_W*int'(idx) +: TILE_W] <= DOT_CODE;
                  dot_count <= dot_count + 11'd1;
               end
               idx <= idx + IDX_W'(1);
               if (col == COL_W'(COLS - 1)) begin
                  col <= '0;
                  row <= row + ROW_W'(1);
               end else begin
                  col <= col + COL_W'(1);
               end
               if (idx == IDX_W'(NTILES - 1)) begin
                  state     <= IDLE;
                  init_done <= 1'b1;
                  idx       <= '0;
                  row       <= '0;
                  col       <= '0;
               end
            end
            IDLE: begin
               if (clear) begin
                  state     <= INIT;
                  idx       <= '0;
                  row       <= '0;
                  col       <= '0;
                  dot_count <= '0;
                  init_done <= 1'b0;
               end else if (wr_accept) begin
                  if (wr_in_range) begin
                     map_out[TILE_W*int'(bus.wr_index) +: TILE_W] <= bus.wr_data;
                     if (old_tile == DOT_CODE && bus.wr_data != DOT_CODE)
                        dot_count <= dot_count - 11'd1;
                     else if (old_tile != DOT_CODE && bus.wr_data == DOT_CODE)
                        dot_count <= dot_count + 11'd1;
                  end else begin
                     bus.wr_err <= 1'b1;
                  end
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_tile_map_writer.sv
module tb_tile_map_writer;

   localparam int ROWS = 30;
   localparam int COLS = 40;
   localparam int TW   = 8;
   localparam int NT   = ROWS * COLS;

   logic             Clk   = 1'b0;
   logic             Reset = 1'b1;
   logic             clear = 1'b0;
   logic [NT*TW-1:0] map_out;
   logic             init_done;
   logic [10:0]      dot_count;

   always #5 Clk = ~Clk;

   tile_map_writer_if #(.IDX_W(12), .TILE_W(TW)) bus();

   tile_map_writer #(
      .ROWS(ROWS), .COLS(COLS), .TILE_W(TW),
      .DOT_CODE(8'h01), .WALL_CODE(8'h02)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .clear     (clear),
      .bus       (bus.slave),
      .map_out   (map_out),
      .init_done (init_done),
      .dot_count (dot_count)
   );

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] model [NT];
   int         model_dots;

   typedef struct {
      int         idx;
      logic [7:0] tile;
      int         dots;
      logic       err;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] maze(input int k);
      int r, c;
      r = k / COLS;
      c = k % COLS;
      if (r == 0 || r == ROWS-1 || c == 0 || c == COLS-1) return 8'h02;
      return 8'h01;
   endfunction

   function automatic logic [7:0] tile(input int k);
      return map_out[TW*k +: TW];
   endfunction

   task automatic model_init();
      model_dots = 0;
      for (int k = 0; k < NT; k++) begin
         model[k] = maze(k);
         if (model[k] == 8'h01) model_dots++;
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_map(input string tag);
      logic [NT*TW-1:0] em;
      for (int k = 0; k < NT; k++) em[TW*k +: TW] = model[k];
      check(tag, 32'(map_out === em), 32'd1);
   endtask

   // Counts edges until init_done rises; bounded so a stuck DUT still ends.
   task automatic wait_init(input string tag);
      int n;
      n = 0;
      while (init_done !== 1'b1 && n < 1300) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'd1200);
   endtask

   task automatic push_write(input int idx, input logic [7:0] data);
      exp_t e;
      if (idx < NT) begin
         if (model[idx] == 8'h01 && data != 8'h01) model_dots--;
         else if (model[idx] != 8'h01 && data == 8'h01) model_dots++;
         model[idx] = data;
         e.idx = idx;
         e.err = 1'b0;
      end else begin
         e.idx = 41;
         e.err = 1'b1;
      end
      e.tile = model[e.idx];
      e.dots = model_dots;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb.pop_front();
      check($sformatf("tile%0d", e.idx), 32'(tile(e.idx)), 32'(e.tile));
      check("dot_count", 32'(dot_count), 32'(e.dots));
      check("wr_err", 32'(bus.wr_err), 32'(e.err));
   endtask

   // Drives one request; leaves wr_valid high so callers can chain back-to-back.
   task automatic drive(input int idx, input logic [7:0] data);
      bus.wr_valid = 1'b1;
      bus.wr_index = 12'(idx);
      bus.wr_data  = data;
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      push_write(idx, data);
      tick();
      pop_check();
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_index = '0;
      bus.wr_data  = '0;

      // 1: reset, then maze load
      tick();
      tick();
      check("rst_map_zero", 32'(map_out === '0), 32'd1);
      check("rst_dot_count", 32'(dot_count), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_wr_err", 32'(bus.wr_err), 32'd0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      Reset = 1'b0;
      model_init();
      wait_init("init_edges");
      check("init_dot_count", 32'(dot_count), 32'd1064);
      check("init_model_dots", 32'(dot_count), 32'(model_dots));
      check("init_tile0", 32'(tile(0)), 32'h02);
      check("init_tile41", 32'(tile(41)), 32'h01);
      check("init_tile1199", 32'(tile(1199)), 32'h02);
      check_map("init_map");

      // 2: eat a dot, restore it
      drive(41, 8'h00);
      bus.wr_valid = 1'b0;
      tick();
      drive(41, 8'h01);
      bus.wr_valid = 1'b0;
      // same-code rewrite changes nothing
      drive(1, 8'h02);
      bus.wr_valid = 1'b0;

      // 3: out-of-range write
      drive(1200, 8'h05);
      bus.wr_valid = 1'b0;
      tick();
      check("wr_err_one_cycle", 32'(bus.wr_err), 32'd0);
      check_map("oor_map_unchanged");

      // 4: back-to-back writes
      drive(41, 8'h00);
      drive(42, 8'h00);
      drive(43, 8'h00);
      bus.wr_valid = 1'b0;
      check("b2b_dot_count", 32'(dot_count), 32'd1061);
      drive(41, 8'h01);
      bus.wr_valid = 1'b0;
      drive(0, 8'h01);
      bus.wr_valid = 1'b0;
      check_map("after_writes_map");

      // 5: clear beats a pending write
      clear        = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_index = 12'd41;
      bus.wr_data  = 8'h00;
      #1;
      check("clear_wr_ready", 32'(bus.wr_ready), 32'd0);
      tick();
      clear        = 1'b0;
      bus.wr_valid = 1'b0;
      check("clear_init_done", 32'(init_done), 32'd0);
      check("clear_dot_count", 32'(dot_count), 32'd0);
      check("clear_no_write", 32'(tile(41)), 32'h01);
      model_init();
      wait_init("reinit_edges");
      check("reinit_dot_count", 32'(dot_count), 32'd1064);
      check("reinit_tile41", 32'(tile(41)), 32'h01);
      check_map("reinit_map");

      // 6: reset in the middle of a maze load
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (600) tick();
      check("mid_init_done", 32'(init_done), 32'd0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("midrst_map_zero", 32'(map_out === '0), 32'd1);
      check("midrst_dot_count", 32'(dot_count), 32'd0);
      check("midrst_init_done", 32'(init_done), 32'd0);
      wait_init("post_rst_edges");
      check("post_rst_dot_count", 32'(dot_count), 32'd1064);
      check_map("post_rst_map");

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
